// File: rtl/hdb3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hdb3_pkg
//  Description : Shared encodings for the HDBn line-encoder slice.
//                Ternary polar codes (P/N/Z) and delay-line symbol tags
//                (ZERO/ONE/B/V). These are the same encodings that the
//                dual-to-ternary polarity stage uses.
//  Revision    : 1.0  initial release
// ============================================================================
package hdb3_pkg;

    // Ternary line codes
    localparam logic [1:0] c_pol_p = 2'b10;  // +1
    localparam logic [1:0] c_pol_n = 2'b01;  // -1
    localparam logic [1:0] c_pol_z = 2'b00;  //  0

    // Symbol tags carried through the delay line
    localparam logic [1:0] c_tag_zero = 2'b00;
    localparam logic [1:0] c_tag_one  = 2'b01;
    localparam logic [1:0] c_tag_b    = 2'b10;
    localparam logic [1:0] c_tag_v    = 2'b11;

    // Map a polarity flag (1 = positive) to its ternary code
    function automatic logic [1:0] pol_code(input logic positive);
        return positive ? c_pol_p : c_pol_n;
    endfunction

endpackage : hdb3_pkg
`default_nettype wire

// File: rtl/hdbn_polar.sv
`default_nettype none
// ============================================================================
//  Module      : hdbn_polar
//  Description : Polarity sub-stage. It tracks the polarity of the last mark
//                and maps each departing tag to a ternary code. Marks and B
//                pulses alternate, while V repeats the last polarity. In RZ
//                mode the code returns to zero one cycle after each load.
//  Ports       : clk, rst     - clock, async active-high reset
//                load_i       - a valid entry departs the delay line
//                tag_i        - tag of the departing entry
//                polar_o      - ternary code (10 = +1, 01 = -1, 00 = 0)
//                sym_o        - tag of the most recently emitted entry
//                valid_o      - one-cycle pulse on each update
//  Revision    : 1.0  initial release
// ============================================================================
module hdbn_polar
    import hdb3_pkg::*;
#(
    parameter int RZ_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [1:0] tag_i,
    output logic [1:0] polar_o,
    output logic [1:0] sym_o,
    output logic       valid_o
);

    logic       last_pol_q, last_pol_d;   // 1 = last mark was positive
    logic [1:0] polar_q, code_d;
    logic [1:0] sym_q;
    logic       valid_q;

    always_comb begin
        last_pol_d = last_pol_q;
        code_d     = c_pol_z;
        case (tag_i)
            c_tag_one, c_tag_b: begin
                last_pol_d = ~last_pol_q;
                code_d     = pol_code(~last_pol_q);
            end
            // A violation repeats the previous polarity and leaves it as is
            c_tag_v: code_d = pol_code(last_pol_q);
            default: code_d = c_pol_z;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pol_q <= 1'b0;           // first mark comes out as +1
            polar_q    <= c_pol_z;
            sym_q      <= c_tag_zero;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            last_pol_q <= last_pol_d;
            polar_q    <= code_d;
            sym_q      <= tag_i;
            valid_q    <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            if (RZ_MODE != 0) begin
                polar_q <= c_pol_z;       // return to zero, tag is kept
            end
        end
    end

    assign polar_o = polar_q;
    assign sym_o   = sym_q;
    assign valid_o = valid_q;

endmodule : hdbn_polar
`default_nettype wire

// File: rtl/hdbn_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : hdbn_encoder
//  Description : HDBn line encoder. Accepted NRZ bits pass through a
//                ZERO_RUN-deep lookahead delay line. When the run of zeros
//                reaches ZERO_RUN, it is rewritten in place as 0..0V or
//                B0..0V. Departing entries then go through the polarity
//                stage. Output is NRZ or RZ ternary.
//  Ports       : clk, rst     - clock, async active-high reset
//                in_valid     - accept strobe for in_bit
//                in_bit       - binary data bit
//                polar_out    - ternary code (10 = +1, 01 = -1, 00 = 0)
//                sym_out      - emitted tag (00 zero, 01 one, 10 B, 11 V)
//                out_valid    - one-cycle pulse when the outputs update
//                err_overrun  - sticky RZ back-to-back accept flag
//  Revision    : 1.0  initial release
// ============================================================================
module hdbn_encoder
    import hdb3_pkg::*;
#(
    parameter int ZERO_RUN = 4,   // legal range 2..8
    parameter int RZ_MODE  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic [1:0] polar_out,
    output logic [1:0] sym_out,
    output logic       out_valid,
    output logic       err_overrun
);

    localparam int              CNT_W      = $clog2(ZERO_RUN + 1);
    localparam logic [CNT_W-1:0] c_run_last = CNT_W'(ZERO_RUN - 1);

    // line[0] is the newest entry, line[ZERO_RUN-1] is the next to depart
    logic [ZERO_RUN-1:0][1:0] tag_q, tag_d;
    logic [ZERO_RUN-1:0]      vld_q, vld_d;
    logic [CNT_W-1:0]         zero_cnt_q, zero_cnt_d;
    logic                     parity_q, parity_d;   // marks since last V, mod 2
    logic                     in_valid_prev_q;
    logic                     err_q;
    logic                     load_w;

    always_comb begin
        tag_d      = tag_q;
        vld_d      = vld_q;
        zero_cnt_d = zero_cnt_q;
        parity_d   = parity_q;
        if (in_valid) begin
            for (int i = ZERO_RUN - 1; i > 0; i--) begin
                tag_d[i] = tag_q[i-1];
                vld_d[i] = vld_q[i-1];
            end
            vld_d[0] = 1'b1;
            if (in_bit) begin
                tag_d[0]   = c_tag_one;
                zero_cnt_d = '0;
                parity_d   = ~parity_q;
            end else if (zero_cnt_q == c_run_last) begin
                // Whole run is now in the line: the newest zero becomes V.
                // With an even mark count, the oldest zero becomes B so that
                // successive violations alternate in polarity.
                tag_d[0] = c_tag_v;
                if (!parity_q) begin
                    tag_d[ZERO_RUN-1] = c_tag_b;
                end
                zero_cnt_d = '0;
                parity_d   = 1'b0;
            end else begin
                tag_d[0]   = c_tag_zero;
                zero_cnt_d = zero_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q           <= '0;
            vld_q           <= '0;
            zero_cnt_q      <= '0;
            parity_q        <= 1'b0;
            in_valid_prev_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            tag_q           <= tag_d;
            vld_q           <= vld_d;
            zero_cnt_q      <= zero_cnt_d;
            parity_q        <= parity_d;
            in_valid_prev_q <= in_valid;
            if ((RZ_MODE != 0) && in_valid && in_valid_prev_q) begin
                err_q <= 1'b1;
            end
        end
    end

    // The pre-shift oldest entry departs on every accept. Only entries that
    // were actually written since reset produce output.
    assign load_w = in_valid & vld_q[ZERO_RUN-1];

    hdbn_polar #(
        .RZ_MODE (RZ_MODE)
    ) u_polar (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_w),
        .tag_i   (tag_q[ZERO_RUN-1]),
        .polar_o (polar_out),
        .sym_o   (sym_out),
        .valid_o (out_valid)
    );

    assign err_overrun = err_q;

endmodule : hdbn_encoder
`default_nettype wire

// File: tb/tb_hdbn_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdbn_encoder
//  Description : Self-checking bench for hdbn_encoder. Three instances share
//                one stimulus: HDB3 NRZ, HDB3 RZ, and ZERO_RUN=3 NRZ. The
//                variable sel picks which instance the scoreboard follows.
//                Expected {tag, polar} pairs are queued as stimulus is
//                driven and popped on each out_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hdbn_encoder;

    localparam logic [1:0] T0 = 2'b00, T1 = 2'b01, TB = 2'b10, TV = 2'b11;
    localparam logic [1:0] P  = 2'b10, N  = 2'b01, Z  = 2'b00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_bit;
    logic [1:0] p4, s4, pr, sr, p3, s3;
    logic       v4, e4, vr, er, v3, e3;

    hdbn_encoder #(.ZERO_RUN(4), .RZ_MODE(0)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .polar_out(p4), .sym_out(s4), .out_valid(v4), .err_overrun(e4));

    hdbn_encoder #(.ZERO_RUN(4), .RZ_MODE(1)) u_dut_rz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .polar_out(pr), .sym_out(sr), .out_valid(vr), .err_overrun(er));

    hdbn_encoder #(.ZERO_RUN(3), .RZ_MODE(0)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .polar_out(p3), .sym_out(s3), .out_valid(v3), .err_overrun(e3));

    int         sel;
    int         n_pass  = 0;
    int         n_total = 0;
    logic [3:0] exp_q[$];      // {tag, polar}
    logic [3:0] mon_e;
    logic [1:0] mon_p, mon_s;
    logic       mon_v;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push(input logic [1:0] t, input logic [1:0] p);
        exp_q.push_back({t, p});
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        exp_q.delete();
        idle(2);
        check("reset_outputs", {p4, s4, v4, e4}, 8'h00);
        check("reset_outputs_rz", {pr, sr, vr, er}, 8'h00);
        rst = 1'b0;
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            case (sel)
                1:       begin mon_p = pr; mon_s = sr; mon_v = vr; end
                2:       begin mon_p = p3; mon_s = s3; mon_v = v3; end
                default: begin mon_p = p4; mon_s = s4; mon_v = v4; end
            endcase
            if (mon_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 8'(mon_v), 8'h00);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sym_out", 8'(mon_s), 8'(mon_e[3:2]));
                    check("polar_out", 8'(mon_p), 8'(mon_e[1:0]));
                end
            end
            if (sel == 1 && pr != Z) begin
                check("rz_pulse_width", 8'(vr), 8'h01);
            end
        end
    end

    initial begin
        logic [9:0]  pat10;
        logic [11:0] pat12;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; sel = 0;

        // Test 1: 1,0,0,0,0,1 then 1,1,1,1 (NRZ, back-to-back)
        do_reset();
        push(T1, P); push(T0, Z); push(T0, Z); push(T0, Z); push(TV, P); push(T1, N);
        pat10 = 10'b1000011111;
        for (int i = 9; i >= 0; i--) send(pat10[i]);
        idle(3);
        check("t1_drain", 8'(exp_q.size()), 8'h00);
        check("t1_nrz_no_overrun", 8'(e4), 8'h00);

        // Test 2: 1,1,0,0,0,0 then four 1s
        do_reset();
        push(T1, P); push(T1, N); push(TB, P); push(T0, Z); push(T0, Z); push(TV, P);
        pat10 = 10'b1100001111;
        for (int i = 9; i >= 0; i--) send(pat10[i]);
        idle(3);
        check("t2_drain", 8'(exp_q.size()), 8'h00);

        // Test 3: eight 0s then four 1s
        do_reset();
        push(TB, P); push(T0, Z); push(T0, Z); push(TV, P);
        push(TB, N); push(T0, Z); push(T0, Z); push(TV, N);
        pat12 = 12'b000000001111;
        for (int i = 11; i >= 0; i--) send(pat12[i]);
        idle(3);
        check("t3_drain", 8'(exp_q.size()), 8'h00);

        // Test 4: reset in the middle of a run
        do_reset();
        send(1'b1); send(1'b0); send(1'b0);
        rst = 1'b1;
        idle(1);
        check("t4_in_reset", {p4, s4, v4, e4}, 8'h00);
        idle(1);
        check("t4_in_reset2", {p4, s4, v4, e4}, 8'h00);
        rst = 1'b0;
        push(TB, P); push(T0, Z); push(T0, Z); push(TV, P);
        pat10 = 10'b0000111100;
        for (int i = 9; i >= 2; i--) send(pat10[i]);
        idle(3);
        check("t4_drain", 8'(exp_q.size()), 8'h00);

        // Test 5: RZ, accepts spaced every 2 cycles, then an overrun
        do_reset();
        sel = 1;
        push(T1, P); push(T1, N);
        for (int i = 0; i < 6; i++) begin
            send(1'b1);
            idle(1);
        end
        idle(2);
        check("t5_drain", 8'(exp_q.size()), 8'h00);
        check("t5_no_overrun", 8'(er), 8'h00);
        push(T1, P); push(T1, N);
        send(1'b1); send(1'b1);
        idle(1);
        check("t5_overrun_set", 8'(er), 8'h01);
        idle(5);
        check("t5_overrun_held", 8'(er), 8'h01);
        check("t5_drain2", 8'(exp_q.size()), 8'h00);
        check("t5_rz_idle_zero", 8'(pr), 8'h00);
        do_reset();
        check("t5_overrun_cleared", 8'(er), 8'h00);

        // Test 6: ZERO_RUN = 3, 1,0,0,0 then three 1s
        sel = 2;
        push(T1, P); push(T0, Z); push(T0, Z); push(TV, P);
        pat10 = 10'b1000111000;
        for (int i = 9; i >= 3; i--) send(pat10[i]);
        idle(3);
        check("t6_drain", 8'(exp_q.size()), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net in case the run ever stops advancing
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule : tb_hdbn_encoder
`default_nettype wire

// File: doc/hdbn_encoder.md
Name: hdbn_encoder

Overview:
Full HDBn line encoder that generalises the existing dual-to-ternary polarity stage. It takes a binary NRZ bit stream with a valid strobe and performs zero-run substitution (0…0V / B0…0V) through a lookahead delay line. It then assigns AMI/violation polarity and drives a 2-bit ternary code in NRZ or RZ form. It sits between the framer bit source and the line-driver interface.

Parameters:
ZERO_RUN, 4, length of the zero run that is replaced; legal range 2..8 (4 = HDB3, 3 = HDB2/B3ZS-style).
RZ_MODE, 0, 0 = NRZ: code held until the next output. 1 = RZ: code driven for one cycle, then forced to zero.

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  asynchronous, active-high reset
in_valid  in  1  strobe; in_bit is accepted on a rising edge while this is high
in_bit  in  1  binary data bit
polar_out  out  2  ternary code: 2'b10 = +1, 2'b01 = −1, 2'b00 = 0
sym_out  out  2  symbol tag of the emitted entry: 00 = zero, 01 = one, 10 = B, 11 = V
out_valid  out  1  one-cycle pulse when polar_out/sym_out update
err_overrun  out  1  sticky RZ pacing-violation flag

Behaviour:
- Reset (async, any time, including mid-run):
  - polar_out, sym_out, out_valid and err_overrun go to 0.
  - All delay-line entries go to tag zero, with their entry-valid bits cleared.
  - zero_cnt = 0, parity = 0, last_pol = negative (so the first pulse is +1).
- Delay line:
  - line[0..ZERO_RUN-1] holds tag plus entry-valid; line[0] is newest.
  - On each accept, every entry shifts one place and line[0] receives the new tag (01 if in_bit = 1, else 00).
  - The pre-shift line[ZERO_RUN-1] is the departing entry.
- Zero counter:
  - Accepted 1: zero_cnt = 0.
  - Accepted 0: zero_cnt++.
- Substitution, on accepting a 0 with zero_cnt == ZERO_RUN-1:
  - The new entry is written as V.
  - If parity == 0, the entry that lands at post-shift line[ZERO_RUN-1] (the oldest zero of the run) is rewritten as B in the same edge; if parity == 1 it stays zero.
  - Then zero_cnt = 0 and parity = 0.
- Parity: toggles on every accepted 1. The B insertion and V reset are absorbed by the substitution rule above.
- Runs longer than ZERO_RUN substitute repeatedly. 2×ZERO_RUN zeros produce two complete substitution groups.
- Output:
  - Registered, one clk after the accept edge.
  - out_valid = 1 only if the departing entry was entry-valid. The first ZERO_RUN accepts after reset produce no out_valid.
  - Effective latency is ZERO_RUN accepts + 1 clk. There is no flush; the pipeline drains only through further accepts.
- Polarity (polarity sub-stage):
  - Tag 01 or B: pol = ~last_pol, then last_pol = pol.
  - Tag V: pol = last_pol, and last_pol is unchanged.
  - Tag zero: code 00, last_pol unchanged.
- Code hold:
  - NRZ: polar_out and sym_out hold between out_valid pulses.
  - RZ: polar_out returns to 00 on the cycle after out_valid; sym_out holds.
- Pacing and idle:
  - In RZ mode, in_valid high on two consecutive cycles sets err_overrun. It stays set until rst, and both bits are still processed.
  - In NRZ mode, back-to-back in_valid is legal and err_overrun stays 0.
  - in_valid low: no state change; out_valid stays 0.

Decomposition:
- Package hdb3_pkg: polar code constants (P/N/Z) and symbol-tag constants (ZERO/ONE/B/V). The existing dual-to-ternary stage uses the same encodings.
- One sub-module, hdbn_polar: holds last_pol, maps tag → polar_out, and implements the RZ return-to-zero.
- The delay line, counters and substitution logic stay in hdbn_encoder.

Test Plan:
1. Reset; accept 1,0,0,0,0,1 then 1,1,1,1 (back-to-back, NRZ).
   - First six out_valid tags: 1,0,0,0,V,1.
   - polar: +1,0,0,0,+1,−1.
2. Reset; accept 1,1,0,0,0,0 then four 1s.
   - Tags: 1,1,B,0,0,V.
   - polar: +1,−1,+1,0,0,+1.
3. Reset; accept eight 0s then four 1s.
   - Tags: B,0,0,V,B,0,0,V.
   - polar: +1,0,0,+1,−1,0,0,−1.
4. Reset mid-run: accept 1,0,0, assert rst for 2 cycles, then accept 0,0,0,0,1,1,1,1.
   - All outputs are 0 during reset.
   - Then tags B,0,0,V; polar +1,0,0,+1.
   - No stale out_valid from pre-reset bits.
5. RZ_MODE=1, accepts spaced every 2 cycles, pattern 1,1,1,1,1,1.
   - polar_out is nonzero for exactly one cycle per out_valid.
   - Polarities alternate: +1,−1.
   - err_overrun stays 0.
   - Then two consecutive in_valid → err_overrun = 1, held until rst.
6. ZERO_RUN=3: accept 1,0,0,0 then three 1s.
   - Tags: 1,0,0,V.
   - polar: +1,0,0,+1.
